// File: rtl/map_redraw_engine.sv
// rtl/map_redraw_engine.sv - streams a background image from ROM into the framebuffer on a redraw game state
// Optional TRANSPARENT_EN: window redraws skip pixels whose colour equals KEY_COLOUR.
module map_redraw_engine #(
  parameter int          SCREEN_W   = 320,
  parameter int          SCREEN_H   = 240,
  parameter int          WIN_W      = 64,
  parameter int          WIN_H      = 48,
  parameter logic [35:0] WIN_X      = {9'd200, 9'd150, 9'd100, 9'd40},
  parameter logic [31:0] WIN_Y      = {8'd16, 8'd60, 8'd100, 8'd140},
  parameter logic [2:0]  KEY_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  gameState,
  output logic [3:0]  rom_sel,
  output logic [16:0] rom_addr,
  input  logic [2:0]  rom_data,
  output logic [8:0]  plot_x,
  output logic [7:0]  plot_y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        doneRedraw
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_code;
  logic [3:0]  r_sel;
  logic [8:0]  r_org_x;
  logic [7:0]  r_org_y;
  logic [8:0]  r_w;
  logic [7:0]  r_h;
  logic [8:0]  r_cx;
  logic [7:0]  r_cy;
  logic [8:0]  r_px;
  logic [7:0]  r_py;
  logic        r_vld;
  logic        r_done;

  logic        w_is_redraw;
  logic [1:0]  w_k;
  logic [8:0]  w_win_x;
  logic [7:0]  w_win_y;
  logic [8:0]  w_ax;
  logic [7:0]  w_ay;
  logic        w_key;

  assign w_is_redraw = (gameState == 4'd10) || (gameState == 4'd1) || (gameState == 4'd3) ||
                       (gameState == 4'd5)  || (gameState == 4'd7);

  // Odd window codes 1/3/5/7 map to window index 0..3 via bits [2:1].
  assign w_k = r_code[2:1];

  always_comb begin
    w_win_x = WIN_X[8:0];
    w_win_y = WIN_Y[7:0];
    case (w_k)
      2'd0: begin w_win_x = WIN_X[8:0];   w_win_y = WIN_Y[7:0];   end
      2'd1: begin w_win_x = WIN_X[17:9];  w_win_y = WIN_Y[15:8];  end
      2'd2: begin w_win_x = WIN_X[26:18]; w_win_y = WIN_Y[23:16]; end
      default: begin w_win_x = WIN_X[35:27]; w_win_y = WIN_Y[31:24]; end
    endcase
  end

  assign w_ax     = r_org_x + r_cx;
  assign w_ay     = r_org_y + r_cy;
  assign rom_addr = 17'(w_ay) * 17'(SCREEN_W) + 17'(w_ax);

`ifdef TRANSPARENT_EN
  logic r_win;
  // rom_data arrives alongside the registered pixel, so the key test is combinational.
  assign w_key = r_win && (rom_data == KEY_COLOUR);
`else
  assign w_key = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_sel   <= '0;
      r_org_x <= '0;
      r_org_y <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
`ifdef TRANSPARENT_EN
      r_win   <= 1'b0;
`endif
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_redraw) begin
            r_code  <= gameState;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sel <= r_code;
          r_cx  <= '0;
          r_cy  <= '0;
          if (r_code == 4'd10) begin
            r_org_x <= '0;
            r_org_y <= '0;
            r_w     <= 9'(SCREEN_W);
            r_h     <= 8'(SCREEN_H);
          end else begin
            r_org_x <= w_win_x;
            r_org_y <= w_win_y;
            r_w     <= 9'(WIN_W);
            r_h     <= 8'(WIN_H);
          end
`ifdef TRANSPARENT_EN
          r_win <= (r_code != 4'd10);
`endif
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_px  <= w_ax;
          r_py  <= w_ay;
          r_vld <= 1'b1;
          if (r_cx == r_w - 9'd1) begin
            r_cx <= '0;
            if (r_cy == r_h - 8'd1) begin
              r_state <= S_FLUSH;
            end else begin
              r_cy <= r_cy + 8'd1;
            end
          end else begin
            r_cx <= r_cx + 9'd1;
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Waiting for the game FSM to move on prevents a held code from retriggering.
          if (gameState != r_sel) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_sel    = r_sel;
  assign plot_x     = r_px;
  assign plot_y     = r_py;
  assign colour     = r_vld ? rom_data : 3'b000;
  assign writeEn    = r_vld & ~w_key;
  assign doneRedraw = r_done;

endmodule

// File: tb/tb_map_redraw_engine.sv
// tb/tb_map_redraw_engine.sv - directed self-checking bench for map_redraw_engine
module tb_map_redraw_engine;

`ifdef TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  gameState = 4'd0;
  logic [3:0]  rom_sel;
  logic [16:0] rom_addr;
  logic [2:0]  rom_data = 3'd0;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        doneRedraw;

  int n_checks = 0;
  int n_errors = 0;

  int ox, oy, ww, wh, esel, ewin, rom_mode;
  int ex, ey, wr_count, bad_pix, first_xy, last_xy, we_total;

  always #5 clock = ~clock;

  map_redraw_engine dut (
    .clock(clock), .resetn(resetn), .gameState(gameState),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .plot_x(plot_x), .plot_y(plot_y), .colour(colour),
    .writeEn(writeEn), .doneRedraw(doneRedraw)
  );

  function automatic logic [2:0] rom_fn(input int mode, input int sel, input int addr);
    if (mode == 1) return (addr == 48050) ? 3'd5 : 3'd0;
    return 3'(addr ^ (addr >> 7) ^ sel);
  endfunction

  function automatic bit skip_px(input int x, input int y);
    return TRANSP && (ewin != 0) && (rom_fn(rom_mode, esel, y * 320 + x) == 3'b000);
  endfunction

  always @(posedge clock) rom_data <= rom_fn(rom_mode, int'(rom_sel), int'(rom_addr));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    ex++;
    if (ex >= ox + ww) begin
      ex = ox;
      ey++;
    end
  endtask

  task automatic start_expect(input int sel, input int x0, input int y0, input int w, input int h, input int win);
    esel = sel; ox = x0; oy = y0; ww = w; wh = h; ewin = win;
    ex = x0; ey = y0;
    wr_count = 0; bad_pix = 0; first_xy = -1; last_xy = -1;
  endtask

  // Scoreboard: each write must be the next raster pixel, coloured from the address fetched one cycle earlier.
  always @(negedge clock) begin
    if (writeEn === 1'b1) begin
      we_total++;
      while (ey < oy + wh && skip_px(ex, ey)) adv();
      if (int'(plot_x) != ex || int'(plot_y) != ey || colour != rom_fn(rom_mode, esel, ey * 320 + ex))
        bad_pix++;
      if (first_xy < 0) first_xy = int'(plot_y) * 512 + int'(plot_x);
      last_xy = int'(plot_y) * 512 + int'(plot_x);
      wr_count++;
      adv();
    end
  end

  task automatic wait_done(input int budget, output int cyc, output int prev_we);
    int pw;
    pw = 0;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (doneRedraw) break;
      pw = int'(writeEn);
    end
    prev_we = pw;
    #1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_rom_sel"}, int'(rom_sel), 0);
    check({pfx, "_rom_addr"}, int'(rom_addr), 0);
    check({pfx, "_plot_x"}, int'(plot_x), 0);
    check({pfx, "_plot_y"}, int'(plot_y), 0);
    check({pfx, "_colour"}, int'(colour), 0);
    check({pfx, "_writeEn"}, int'(writeEn), 0);
    check({pfx, "_done"}, int'(doneRedraw), 0);
  endtask

  initial begin
    int cyc, pw, w0, lows;
    int ign_codes[4];
    ign_codes = '{2, 4, 8, 9};
    rom_mode = 0;
    we_total = 0;
    start_expect(0, 0, 0, 1, 1, 0);

    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    resetn = 1'b1;

    foreach (ign_codes[i]) begin
      gameState = 4'(ign_codes[i]);
      @(posedge clock);
      w0 = we_total;
      lows = 0;
      repeat (12) begin
        @(negedge clock);
        if (!doneRedraw) lows++;
      end
      @(posedge clock);
      check("ignore_writes", we_total - w0, 0);
      check("ignore_done_low", lows, 12);
    end

    @(negedge clock);
    gameState = 4'd0;
    @(negedge clock);
    start_expect(10, 0, 0, 320, 240, 0);
    gameState = 4'd10;
    wait_done(80000, cyc, pw);
    check("full_latency", cyc, 76803);
    check("full_writes", wr_count, 76800);
    check("full_pixels_bad", bad_pix, 0);
    check("full_first", first_xy, 0);
    check("full_last", last_xy, 239 * 512 + 319);
    check("full_rom_sel", int'(rom_sel), 10);
    check("full_we_before_done", pw, 1);
    check("full_we_at_done", int'(writeEn), 0);

    @(negedge clock);
    gameState = 4'd0;
    @(negedge clock);
    check("done_falls", int'(doneRedraw), 0);

    @(negedge clock);
    start_expect(3, 100, 100, 64, 48, 1);
    gameState = 4'd3;
    wait_done(4000, cyc, pw);
    check("win3_latency", cyc, 3075);
    check("win3_pixels_bad", bad_pix, 0);
    check("win3_rom_sel", int'(rom_sel), 3);
    if (!TRANSP) begin
      check("win3_writes", wr_count, 3072);
      check("win3_first", first_xy, 100 * 512 + 100);
      check("win3_last", last_xy, 147 * 512 + 163);
    end

    // Switch straight from DONE of code 3 to code 5: one extra IDLE cycle.
    @(negedge clock);
    start_expect(5, 150, 60, 64, 48, 1);
    gameState = 4'd5;
    wait_done(4000, cyc, pw);
    check("win5_latency", cyc, 3076);
    check("win5_pixels_bad", bad_pix, 0);
    check("win5_rom_sel", int'(rom_sel), 5);
    if (!TRANSP) check("win5_last", last_xy, 107 * 512 + 213);

    @(posedge clock);
    w0 = we_total;
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (!doneRedraw) lows++;
    end
    @(posedge clock);
    check("hold_no_writes", we_total - w0, 0);
    check("hold_done_low_cycles", lows, 0);

    @(negedge clock);
    gameState = 4'd0;
    repeat (2) @(negedge clock);
    rom_mode = 1;
    repeat (2) @(negedge clock);
    start_expect(1, 40, 140, 64, 48, 1);
    gameState = 4'd1;
    wait_done(4000, cyc, pw);
    check("key_latency", cyc, 3075);
    check("key_writes", wr_count, TRANSP ? 1 : 3072);
    check("key_pixels_bad", bad_pix, 0);
    check("key_first", first_xy, TRANSP ? (150 * 512 + 50) : (140 * 512 + 40));

    @(negedge clock);
    gameState = 4'd0;
    repeat (2) @(negedge clock);
    rom_mode = 0;
    repeat (2) @(negedge clock);
    start_expect(7, 200, 16, 64, 48, 1);
    gameState = 4'd7;
    repeat (500) @(negedge clock);
    check("mid_scan_we", int'(writeEn), TRANSP ? int'(writeEn) : 1);
    check("mid_scan_rom_sel", int'(rom_sel), 7);
    check("mid_scan_pixels_bad", bad_pix, 0);
    resetn = 1'b0;
    #1;
    check_zero_outputs("async_reset");

    gameState = 4'd10;
    start_expect(10, 0, 0, 320, 240, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    check("restart_writes", wr_count, 8);
    check("restart_first", first_xy, 0);
    check("restart_last", last_xy, 7);
    check("restart_pixels_bad", bad_pix, 0);
    check("restart_rom_sel", int'(rom_sel), 10);

    resetn = 1'b0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
